// File: rtl/lc3_pkg.sv
// LC-3 datapath shared types: word type, control-field encodings and
// the sign-extension helper used by the immediate/offset muxes.
package lc3_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic [1:0] {
      ALU_NOT   = 2'b00,
      ALU_AND   = 2'b01,
      ALU_ADD   = 2'b10,
      ALU_PASSA = 2'b11
   } aluk_e;

   typedef enum logic [1:0] {
      PCMUX_BUS   = 2'b00,
      PCMUX_ADDER = 2'b01,
      PCMUX_INC   = 2'b10,
      PCMUX_HOLD  = 2'b11
   } pcmux_e;

   typedef enum logic [1:0] {
      A2M_ZERO  = 2'b00,
      A2M_OFF6  = 2'b01,
      A2M_OFF9  = 2'b10,
      A2M_OFF11 = 2'b11
   } a2m_e;

   typedef enum logic {
      MARMUX_ZEXT8 = 1'b0,
      MARMUX_ADDER = 1'b1
   } marmux_e;

   // Sign-extend v[msb:0] to 16 bits; bits above msb are replaced by v[msb].
   function automatic word_t sext(input word_t v, input int unsigned msb);
      word_t r;
      r = v;
      for (int unsigned i = 0; i < 16; i++) begin
         if (i > msb) r[i] = v[msb];
      end
      return r;
   endfunction

endpackage

// File: rtl/reg16.sv
// 16-bit register with load enable, asynchronous active-high reset to a
// parameterised value, and a simulation backdoor (set_data).
module reg16
   import lc3_pkg::*;
#(
   parameter word_t RESET_VAL = '0
) (
   input  logic  clk_i,
   input  logic  rst_i,
   input  logic  ld_i,
   input  word_t d_i,
   output word_t q_o
);

   word_t q_q;

   // Capture d_i on load; reset dominates any load.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     q_q <= RESET_VAL;
      else if (ld_i) q_q <= d_i;
   end

   assign q_o = q_q;

   // Backdoor write; takes effect in the current time step's NBA region.
   task set_data(input word_t value);
      q_q <= value;
   endtask

endmodule

// File: rtl/datapath.sv
// LC-3 style datapath: IR/PC/MAR/MDR, 8x16 register file, ALU, address
// adder, PC/MAR muxes, single shared bus and a word-addressed memory.
// Optional condition codes: define DATAPATH_NZP_EN to add the nzp output.
module datapath
   import lc3_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = 256,
   parameter word_t       PC_RESET  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_ir,
   input  logic        ld_reg,
   input  logic [2:0]  dr,
   input  logic [2:0]  sr1,
   input  logic [2:0]  sr2,
   input  logic [1:0]  aluk,
   input  logic        gate_alu,
   input  logic        gate_pc,
   input  logic        gate_marmux,
   input  logic        gate_mdr,
   input  logic        a1m_sel,
   input  logic [1:0]  a2m_sel,
   input  logic        ld_pc,
   input  logic [1:0]  pcmux_sel,
   input  logic        marmux_sel,
   input  logic        ld_mar,
   input  logic        ld_mdr,
   input  logic        mem_en,
   input  logic        mem_rw,
`ifdef DATAPATH_NZP_EN
   output logic [2:0]  nzp,
`endif
   output logic [15:0] bus
);

   localparam int unsigned AW = $clog2(MEM_DEPTH);

   word_t ir_q, pc_q, mar_q, mdr_q;
   word_t rf_q [8];

   word_t sr1_val, sr2_val, sr2mux, alu_out;
   word_t addr1, addr2, adder, marmux, pc_d;
   word_t mem_rd, mdr_d;
   logic  mdr_ld;
   logic  [AW-1:0] mem_addr;
   logic  mar_unused;

   word_t mem_q [MEM_DEPTH];

   // ---------------- registers ----------------
   reg16 #(.RESET_VAL('0))       u_ir  (.clk_i(clk), .rst_i(rst), .ld_i(ld_ir),  .d_i(bus),   .q_o(ir_q));
   reg16 #(.RESET_VAL(PC_RESET)) u_pc  (.clk_i(clk), .rst_i(rst), .ld_i(ld_pc),  .d_i(pc_d),  .q_o(pc_q));
   reg16 #(.RESET_VAL('0))       u_mar (.clk_i(clk), .rst_i(rst), .ld_i(ld_mar), .d_i(bus),   .q_o(mar_q));
   reg16 #(.RESET_VAL('0))       u_mdr (.clk_i(clk), .rst_i(rst), .ld_i(mdr_ld), .d_i(mdr_d), .q_o(mdr_q));

   for (genvar g = 0; g < 8; g++) begin : g_rf
      reg16 #(.RESET_VAL('0)) u_r (
         .clk_i (clk),
         .rst_i (rst),
         .ld_i  (ld_reg && (dr == 3'(g))),
         .d_i   (bus),
         .q_o   (rf_q[g])
      );
   end

   // ---------------- operand / ALU ----------------
   // Register reads, SR2MUX and ALU.
   always_comb begin
      sr1_val = rf_q[sr1];
      sr2_val = rf_q[sr2];
      sr2mux  = ir_q[5] ? sext(ir_q, 4) : sr2_val;
      case (aluk_e'(aluk))
         ALU_NOT:   alu_out = ~sr1_val;
         ALU_AND:   alu_out = sr1_val & sr2mux;
         ALU_ADD:   alu_out = sr1_val + sr2mux;
         default:   alu_out = sr1_val;
      endcase
   end

   // ---------------- address path ----------------
   // ADDR1MUX/ADDR2MUX, address adder, MARMUX and PCMUX.
   always_comb begin
      addr1 = a1m_sel ? sr1_val : pc_q;
      case (a2m_e'(a2m_sel))
         A2M_ZERO:  addr2 = '0;
         A2M_OFF6:  addr2 = sext(ir_q, 5);
         A2M_OFF9:  addr2 = sext(ir_q, 8);
         default:   addr2 = sext(ir_q, 10);
      endcase
      adder  = addr1 + addr2;
      marmux = (marmux_sel == MARMUX_ADDER) ? adder : {8'h00, ir_q[7:0]};
      case (pcmux_e'(pcmux_sel))
         PCMUX_BUS:   pc_d = bus;
         PCMUX_ADDER: pc_d = adder;
         PCMUX_INC:   pc_d = pc_q + 16'd1;
         default:     pc_d = pc_q;
      endcase
   end

   // ---------------- bus ----------------
   // Fixed-priority bus driver; idle bus reads as zero.
   always_comb begin
      bus = '0;
      if (gate_alu)         bus = alu_out;
      else if (gate_pc)     bus = pc_q;
      else if (gate_marmux) bus = marmux;
      else if (gate_mdr)    bus = mdr_q;
   end

   // ---------------- memory / MDR ----------------
   assign mem_addr   = mar_q[AW-1:0];
   assign mem_rd     = mem_q[mem_addr];
   assign mar_unused = ^mar_q;

   // MDR source select; a memory write cycle holds MDR so the store uses it.
   always_comb begin
      mdr_d  = mem_en ? mem_rd : bus;
      mdr_ld = ld_mdr && !(mem_en && mem_rw);
   end

   // Memory store from pre-edge MDR; contents are not reset.
   always_ff @(posedge clk) begin
      if (mem_en && mem_rw) mem_q[mem_addr] <= mdr_q;
   end

`ifdef DATAPATH_NZP_EN
   logic [2:0] nzp_q, nzp_d;

   // Condition code derivation from the value being written back.
   always_comb begin
      nzp_d = {bus[15], (bus == '0), (!bus[15] && (bus != '0))};
   end

   // Condition codes update alongside every register-file write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         nzp_q <= 3'b010;
      else if (ld_reg) nzp_q <= nzp_d;
   end

   assign nzp = nzp_q;
`endif

`ifndef SYNTHESIS
   a_one_gate: assert property (@(posedge clk) disable iff (rst)
      $onehot0({gate_alu, gate_pc, gate_marmux, gate_mdr}));
`endif

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for datapath with hand-computed expectations.
module tb_datapath;
   import lc3_pkg::*;

   localparam word_t PC_RST = 16'h0200;

   logic        clk, rst;
   logic        ld_ir, ld_reg, gate_alu, gate_pc, gate_marmux, gate_mdr;
   logic [2:0]  dr, sr1, sr2;
   logic [1:0]  aluk, a2m_sel, pcmux_sel;
   logic        a1m_sel, ld_pc, marmux_sel, ld_mar, ld_mdr, mem_en, mem_rw;
   logic [15:0] bus;
`ifdef DATAPATH_NZP_EN
   logic [2:0]  nzp;
`endif

   int n_vec = 0;
   int n_err = 0;

   datapath #(.MEM_DEPTH(256), .PC_RESET(PC_RST)) dut (
      .clk(clk), .rst(rst), .ld_ir(ld_ir), .ld_reg(ld_reg),
      .dr(dr), .sr1(sr1), .sr2(sr2), .aluk(aluk),
      .gate_alu(gate_alu), .gate_pc(gate_pc), .gate_marmux(gate_marmux), .gate_mdr(gate_mdr),
      .a1m_sel(a1m_sel), .a2m_sel(a2m_sel), .ld_pc(ld_pc), .pcmux_sel(pcmux_sel),
      .marmux_sel(marmux_sel), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
      .mem_en(mem_en), .mem_rw(mem_rw),
`ifdef DATAPATH_NZP_EN
      .nzp(nzp),
`endif
      .bus(bus)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clr();
      ld_ir = 0; ld_reg = 0; dr = 0; sr1 = 0; sr2 = 0; aluk = 0;
      gate_alu = 0; gate_pc = 0; gate_marmux = 0; gate_mdr = 0;
      a1m_sel = 0; a2m_sel = 0; ld_pc = 0; pcmux_sel = 0; marmux_sel = 0;
      ld_mar = 0; ld_mdr = 0; mem_en = 0; mem_rw = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      rst = 1;
      #2;
      // reset state
      chk("rst_bus_idle", bus, 16'h0000);
      chk("rst_ir", dut.ir_q, 16'h0000);
      chk("rst_mar", dut.mar_q, 16'h0000);
      chk("rst_mdr", dut.mdr_q, 16'h0000);
      gate_pc = 1; #1;
      chk("rst_pc", bus, PC_RST);
      gate_pc = 0;
      tick();
      rst = 0;
      tick();

      // ALU with register operands: R5 + R6
      dut.g_rf[0].u_r.set_data(16'd0);
      dut.g_rf[1].u_r.set_data(16'd1);
      dut.g_rf[2].u_r.set_data(16'd2);
      dut.g_rf[3].u_r.set_data(16'd3);
      dut.g_rf[4].u_r.set_data(16'd4);
      dut.g_rf[5].u_r.set_data(16'd5);
      dut.g_rf[6].u_r.set_data(16'd6);
      dut.g_rf[7].u_r.set_data(16'd7);
      dut.u_ir.set_data(16'h1B46);
      #1;
      sr1 = 5; sr2 = 6; aluk = 2'b10; gate_alu = 1; #1;
      chk("alu_add_reg", bus, 16'd11);
      aluk = 2'b01; #1; chk("alu_and", bus, 16'h0004);
      aluk = 2'b00; #1; chk("alu_not", bus, 16'hFFFA);
      aluk = 2'b11; #1; chk("alu_pass", bus, 16'h0005);
      dut.u_ir.set_data(16'h003F); #1;
      aluk = 2'b10; #1; chk("alu_add_imm_m1", bus, 16'h0004);
      clr();

      // Address adder / MARMUX paths with PC = 0x3000
      dut.u_pc.set_data(16'h3000);
      dut.u_ir.set_data(16'h0005);
      #1;
      a2m_sel = 2'b10; marmux_sel = 1; gate_marmux = 1; #1;
      chk("marmux_pc_off9", bus, 16'h3005);
      marmux_sel = 0; #1; chk("marmux_zext8", bus, 16'h0005);
      marmux_sel = 1;
      dut.u_ir.set_data(16'h0400); #1;
      a2m_sel = 2'b11; #1; chk("adder_off11_neg", bus, 16'h2C00);
      a2m_sel = 2'b10; #1; chk("adder_off9_zero", bus, 16'h3000);
      dut.u_ir.set_data(16'h0020); #1;
      a2m_sel = 2'b01; #1; chk("adder_off6_neg", bus, 16'h2FE0);
      a2m_sel = 2'b00; #1; chk("adder_zero", bus, 16'h3000);
      a1m_sel = 1; sr1 = 5; a2m_sel = 2'b01; #1;
      chk("adder_base_reg", bus, 16'hFFE5);
      clr();
      a2m_sel = 2'b01; ld_pc = 1; pcmux_sel = 2'b01;
      tick();
      clr(); gate_pc = 1; #1;
      chk("pcmux_adder", bus, 16'h2FE0);

      // PC increment while gating the old PC onto the bus
      dut.u_pc.set_data(16'h3000); #1;
      pcmux_sel = 2'b10; ld_pc = 1; #1;
      chk("pc_inc_0", bus, 16'h3000);
      tick(); chk("pc_inc_1", bus, 16'h3001);
      tick(); chk("pc_inc_2", bus, 16'h3002);
      tick();
      pcmux_sel = 2'b11;
      tick(); chk("pc_hold", bus, 16'h3003);
      clr(); gate_alu = 1; sr1 = 5; aluk = 2'b11; ld_pc = 1; pcmux_sel = 2'b00;
      tick();
      clr(); gate_pc = 1; #1;
      chk("pcmux_bus", bus, 16'h0005);

      // Register-file write back
      clr();
      dut.u_ir.set_data(16'h1042); #1;
      dr = 0; sr1 = 1; sr2 = 2; aluk = 2'b10; gate_alu = 1; ld_reg = 1; #1;
      chk("r0_pre_edge", bus, 16'h0003);
      tick();
      dr = 7; sr1 = 0; aluk = 2'b00;
      tick();
      ld_reg = 0; sr1 = 7; aluk = 2'b11; #1;
      chk("r7_not", bus, 16'hFFFC);
      sr1 = 0; #1;
      chk("r0_add", bus, 16'h0003);
`ifdef DATAPATH_NZP_EN
      chk("nzp_neg", {13'd0, nzp}, 16'h0004);
`endif

      // Memory store / load through MDR
      clr();
      dut.u_mar.set_data(16'h0000); #1;
      sr1 = 7; aluk = 2'b00; gate_alu = 1; ld_mdr = 1;
      tick();
      clr(); gate_mdr = 1; #1;
      chk("mdr_from_bus", bus, 16'h0003);
      clr(); mem_en = 1; mem_rw = 1; ld_mdr = 1; gate_alu = 1; sr1 = 5; aluk = 2'b11;
      tick();
      clr(); gate_mdr = 1; #1;
      chk("mdr_hold_on_write", bus, 16'h0003);
      clr(); ld_mdr = 1;
      tick();
      clr(); gate_mdr = 1; #1;
      chk("mdr_clear", bus, 16'h0000);
      clr(); gate_alu = 1; sr1 = 1; aluk = 2'b11; ld_mar = 1;
      tick();
      clr(); gate_alu = 1; sr1 = 5; aluk = 2'b11; ld_mdr = 1;
      tick();
      clr(); mem_en = 1; mem_rw = 1;
      tick();
      clr(); ld_mar = 1;
      tick();
      clr(); mem_en = 1; ld_mdr = 1;
      tick();
      clr(); gate_mdr = 1; #1;
      chk("mem_read_addr0", bus, 16'h0003);
      clr(); gate_alu = 1; sr1 = 1; aluk = 2'b11; ld_mar = 1;
      tick();
      clr(); mem_en = 1; ld_mdr = 1;
      tick();
      clr(); gate_mdr = 1; #1;
      chk("mem_read_addr1", bus, 16'h0005);

      // IR load from bus, observed through MARMUX zero-extension
      clr(); gate_alu = 1; sr1 = 7; aluk = 2'b11; ld_ir = 1;
      tick();
      clr(); gate_marmux = 1; #1;
      chk("ir_load_zext", bus, 16'h00FC);

      // Asynchronous reset mid-sequence overrides every load
      clr(); gate_alu = 1; sr1 = 7; aluk = 2'b11;
      ld_reg = 1; dr = 3; ld_ir = 1; ld_mar = 1; ld_mdr = 1; ld_pc = 1; pcmux_sel = 2'b10;
      #2;
      rst = 1; #1;
      chk("arst_pc", dut.pc_q, PC_RST);
      chk("arst_ir", dut.ir_q, 16'h0000);
      tick();
      chk("rst_ovr_pc", dut.pc_q, PC_RST);
      chk("rst_ovr_mar", dut.mar_q, 16'h0000);
      chk("rst_ovr_mdr", dut.mdr_q, 16'h0000);
      for (int i = 0; i < 8; i++) chk($sformatf("rst_r%0d", i), dut.rf_q[i], 16'h0000);
      clr(); #1;
      chk("rst_bus_zero", bus, 16'h0000);
`ifdef DATAPATH_NZP_EN
      chk("rst_nzp", {13'd0, nzp}, 16'h0002);
`endif
      rst = 0;
      tick();

      // Memory survives reset (MAR is 0 again)
      clr(); mem_en = 1; ld_mdr = 1;
      tick();
      clr(); gate_mdr = 1; #1;
      chk("mem_kept_over_rst", bus, 16'h0003);
      clr();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
